// File: rtl/thermo_frame_decoder_pkg.sv
// rtl/thermo_frame_decoder_pkg.sv - shared constants and lock-state encoding
// Purpose: frame geometry and lock FSM state encoding used by the decoder
//          and its frame index counter.
package thermo_frame_decoder_pkg;

  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACK    = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/thermo_frame_decoder_frame_idx_counter.sv
// rtl/thermo_frame_decoder_frame_idx_counter.sv - bit index counter within a frame
// Purpose: counts enabled samples 0..FRAME_LEN-1 and wraps.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   en        advance the index on this edge
//   idx       index of the bit sampled at the next enabled edge
//   frame_end high while idx is the last bit of the frame
module frame_idx_counter
  import thermo_frame_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             frame_end
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + 1'b1;
    end
  end

  assign frame_end = (idx == IDX_W'(FRAME_LEN - 1));

endmodule

// File: rtl/thermo_frame_decoder.sv
// rtl/thermo_frame_decoder.sv - serial thermometer frame decoder with lock tracking
// Purpose: decodes 8-bit serial thermometer frames into a 3-bit select value,
//          flags coding violations and reports lock on repeated values.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   din    serial frame bit, bit index 0 first
//   en     sample enable; 0 freezes all frame state
//   s_out  last decoded select value
//   valid  one-cycle pulse when s_out was updated by a good frame
//   err    one-cycle pulse when a frame broke thermometer coding
//   locked high while the last two frames were good and equal
module thermo_frame_decoder
  import thermo_frame_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       en,
  output logic [2:0] s_out,
  output logic       valid,
  output logic       err,
  output logic       locked
);

  logic [IDX_W-1:0] idx;
  logic             frame_end;
  logic             frame_start;

  logic [3:0]  ones, ones_base, ones_next;
  logic        seen_zero, zero_base, zero_next;
  logic        violation, viol_base, viol_next;
  logic [2:0]  decoded;

  lock_state_t state, state_next;
  logic        valid_next, err_next;
  logic [2:0]  s_out_next;

  frame_idx_counter u_idx (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .idx       (idx),
    .frame_end (frame_end)
  );

  assign frame_start = (idx == '0);

  // Per-frame accumulators restart on the idx-0 sample rather than being
  // cleared at frame end, so the final sample is folded in combinationally.
  always_comb begin
    ones_base = frame_start ? 4'd0 : ones;
    zero_base = frame_start ? 1'b0 : seen_zero;
    viol_base = frame_start ? 1'b0 : violation;
    ones_next = ones_base + {3'b000, din};
    zero_next = zero_base | ~din;
    viol_next = viol_base | (frame_start & ~din) | (din & zero_base);
    // A good frame always has at least one 1, so ones_next >= 1 here.
    decoded   = 3'(ones_next - 4'd1);
  end

  // s_out doubles as the tracked value: it always holds the last good frame,
  // and any bad frame drops the FSM back to UNLOCKED.
  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    err_next   = 1'b0;
    s_out_next = s_out;
    if (en && frame_end) begin
      if (viol_next) begin
        err_next   = 1'b1;
        state_next = ST_UNLOCKED;
      end else begin
        valid_next = 1'b1;
        s_out_next = decoded;
        case (state)
          ST_UNLOCKED: state_next = ST_TRACK;
          ST_TRACK,
          ST_LOCKED:   state_next = (decoded == s_out) ? ST_LOCKED : ST_TRACK;
          default:     state_next = ST_UNLOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones      <= '0;
      seen_zero <= 1'b0;
      violation <= 1'b0;
    end else if (en) begin
      ones      <= ones_next;
      seen_zero <= zero_next;
      violation <= viol_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_UNLOCKED;
      s_out  <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      s_out  <= s_out_next;
      valid  <= valid_next;
      err    <= err_next;
      locked <= (state_next == ST_LOCKED);
    end
  end

endmodule
